key_matrix_scanner: RTL and testbench
=====================================

Name: key_matrix_scanner

Overview:
- 4x4 keypad front-end for the 4-bit CPU: the input-direction counterpart of the CPU's multiplexed row/col LED output.
- Drives keypad rows one at a time (active-low) and senses the columns (active-low, pulled up).
- Debounces the full 16-key image, turns new presses into 4-bit key codes, and hands them to the CPU through a valid/ack register interface.
- The CPU reads the code into a register, replacing the raw `btn` sampling.

Parameters:
- SCAN_DIV_BITS, 13: each row slot lasts 2^SCAN_DIV_BITS clocks; must be >= 2.
- DEBOUNCE, 4: number of consecutive identical full scans required before the debounced image changes; range 1..15.

Ports:
- clk  in  1  system clock; the only clock.
- rst  in  1  asynchronous, active-low reset.
- col_in  in  4  keypad column sense; active-low; asynchronous to clk.
- key_ack  in  1  consumer pulse; clears key_valid.
- row_drv  out  4  keypad row drive; active-low; one-hot-low.
- key_valid  out  1  a key code is pending.
- key_code  out  4  pending key index = row*4 + col.
- key_down  out  16  debounced key levels; bit i = key i held.
- overrun  out  1  sticky flag: a press was lost because key_valid was still high.

Behaviour:
- Reset (rst=0, asynchronous):
  - row_drv=4'b1111; key_valid=0; key_code=0; key_down=0; overrun=0.
  - Scan counter, synchronizer flops, raw image, stable count and scan image all cleared.
- Scan timing:
  - Free-running counter, width SCAN_DIV_BITS+2. Row index = top 2 bits.
  - row_drv[r]=0 only while the row index equals r; other rows are 1. Rows go 0,1,2,3, then wrap to 0.
- Sampling:
  - col_in passes through a 2-flop synchronizer.
  - On the last clock of each row slot (low SCAN_DIV_BITS counter bits all 1), the four bits ~col_sync are captured into raw bits [r*4 +: 4].
- End of scan (sample in row 3), using the completed 16-bit image:
  - If image != previous scan image: stable count = 1. Otherwise stable count increments, saturating at DEBOUNCE.
  - Previous scan image <= image.
  - If stable count (post-update) == DEBOUNCE and image != key_down: key_down <= image. The new pressed set = image & ~old key_down.
- Event generation (same clock as the key_down update):
  - If the new pressed set is non-zero, the event is its lowest set bit index.
  - Other simultaneously new presses are dropped silently; they remain visible on key_down.
  - Releases generate no event.
- Handshake:
  - key_valid=0 and an event occurs: key_valid<=1, key_code<=index.
  - key_valid=1 and an event occurs, no ack: event dropped, overrun<=1, key_code unchanged.
  - key_ack while key_valid=1, no event: key_valid<=0 next clock.
  - key_ack and event in the same clock: key_valid stays 1, key_code<=new index, no overrun.
  - key_ack while key_valid=0: ignored.
  - overrun clears only on reset.
- Latency:
  - A press held stable becomes a key_valid assertion one clock after the end-of-scan sample of the DEBOUNCE-th identical scan.
  - If the press started mid-scan, the first partial scan counts as a differing scan.
- Bounce: any mismatch between consecutive scans restarts the stable count at 1. Glitches shorter than one scan never change key_down.
- Reset mid-scan: the scan restarts at row 0 and the count from 0; keys held through reset are reported as new presses after DEBOUNCE scans.

Decomposition:
- Shared package kbd_pkg:
  - constants KBD_ROWS=4, KBD_COLS=4;
  - typedef key_code_t (4-bit);
  - typedef key_image_t (16-bit).
- Sub-module key_image_debounce:
  - inputs: clk, rst, scan_done strobe, 16-bit raw image;
  - outputs: debounced image and a one-clock new_press vector;
  - contains the previous image, the stable count and key_down.
- The top level keeps the row counter, the synchronizer, the priority encoder and the handshake.

Test Plan (SCAN_DIV_BITS=2, i.e. 16 clocks/scan; DEBOUNCE=2):
- Reset then idle, col_in=4'hF:
  - row_drv cycles 1110,1101,1011,0111, 4 clocks each;
  - key_valid, key_down and overrun stay 0 for 10 scans.
- Hold key 6 (col_in[2]=0 while row_drv[1]=0):
  - key_valid=1, key_code=6, key_down=16'h0040 after 2 identical scans;
  - key_ack -> key_valid=0 next clock;
  - release -> key_down=0 after 2 scans, no new event.
- Bounce: toggle key 9 every scan for 6 scans, then hold it:
  - no event during toggling;
  - key_code=9 exactly 2 stable scans after the hold begins.
- Keys 3 and 12 pressed in the same scan:
  - key_code=3, key_down=16'h1008;
  - no second event; overrun=0.
- Press key 1, no ack; release; press key 5:
  - key_valid stays 1, key_code=1, overrun=1.
  - Ack in the same clock as the key-5 event instead: key_code=5, key_valid=1, overrun=0.
- Assert rst low mid-scan while key 15 is held:
  - all outputs cleared immediately;
  - after release of reset, key_code=15 is reported after 2 scans.

Source files
------------

// File: rtl/kbd_pkg.sv
// kbd_pkg: shared definitions for the 4x4 keypad front-end.
//   KBD_ROWS / KBD_COLS / KBD_KEYS : keypad geometry
//   key_code_t                     : 4-bit key index (row*4 + col)
//   key_image_t                    : 16-bit key image, bit i = key i
//   lowest_key()                   : index of the lowest set bit of an image
package kbd_pkg;

  localparam int KBD_ROWS = 4;
  localparam int KBD_COLS = 4;
  localparam int KBD_KEYS = KBD_ROWS * KBD_COLS;

  typedef logic [3:0]          key_code_t;
  typedef logic [KBD_KEYS-1:0] key_image_t;

  // Scanning downward so the last hit wins leaves the lowest index,
  // which gives key 0 the highest priority.
  function automatic key_code_t lowest_key(input key_image_t img);
    key_code_t idx;
    idx = '0;
    for (int i = KBD_KEYS - 1; i >= 0; i--) begin
      if (img[i]) idx = key_code_t'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/key_image_debounce.sv
// key_image_debounce: whole-image debouncer for the keypad scanner.
//   clk        in   system clock
//   rst        in   asynchronous active-low reset
//   scan_done  in   strobe on the clock that completes a full scan
//   raw_image  in   the completed 16-key image (valid with scan_done)
//   key_down   out  debounced key levels
//   new_press  out  keys newly pressed in this update (valid with scan_done)
module key_image_debounce
  import kbd_pkg::*;
#(
  parameter int DEBOUNCE = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scan_done,
  input  key_image_t raw_image,
  output key_image_t key_down,
  output key_image_t new_press
);

  localparam logic [3:0] DEB = 4'(DEBOUNCE);

  key_image_t prev_image;
  logic [3:0] stable_cnt;
  logic [3:0] stable_next;
  logic       commit;

  // The stable count is evaluated combinationally so the new-press vector
  // is available on the scan_done clock itself; the handshake then
  // registers the event on the same edge that updates key_down.
  always_comb begin
    stable_next = stable_cnt;
    commit      = 1'b0;
    new_press   = '0;
    if (scan_done) begin
      if (raw_image != prev_image) begin
        stable_next = 4'd1;
      end else if (stable_cnt != DEB) begin
        stable_next = stable_cnt + 4'd1;
      end
      if ((stable_next == DEB) && (raw_image != key_down)) begin
        commit    = 1'b1;
        new_press = raw_image & ~key_down;
      end
    end
  end

  // Image history and debounced levels only move at the end of a scan.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev_image <= '0;
      stable_cnt <= '0;
      key_down   <= '0;
    end else if (scan_done) begin
      prev_image <= raw_image;
      stable_cnt <= stable_next;
      if (commit) key_down <= raw_image;
    end
  end

endmodule

// File: rtl/key_matrix_scanner.sv
// key_matrix_scanner: 4x4 keypad scanner with debounce and valid/ack output.
//   clk        in   system clock
//   rst        in   asynchronous active-low reset
//   col_in     in   column sense, active-low, asynchronous to clk
//   key_ack    in   consumer pulse clearing key_valid
//   row_drv    out  row drive, active-low, one-hot-low while scanning
//   key_valid  out  a key code is pending
//   key_code   out  pending key index (row*4 + col)
//   key_down   out  debounced key levels
//   overrun    out  sticky: a press was dropped while key_valid was high
module key_matrix_scanner
  import kbd_pkg::*;
#(
  parameter int SCAN_DIV_BITS = 13,
  parameter int DEBOUNCE      = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [KBD_COLS-1:0] col_in,
  input  logic                key_ack,
  output logic [KBD_ROWS-1:0] row_drv,
  output logic                key_valid,
  output key_code_t           key_code,
  output key_image_t          key_down,
  output logic                overrun
);

  logic [SCAN_DIV_BITS+1:0] scan_cnt;
  logic [1:0]               row_idx;
  logic                     slot_end;
  logic                     scan_done;
  logic                     scan_en;
  logic [KBD_COLS-1:0]      col_meta;
  logic [KBD_COLS-1:0]      col_sync;
  key_image_t               raw_image;
  key_image_t               scan_image;
  key_image_t               new_press;
  logic                     event_any;
  key_code_t                event_code;

  assign row_idx   = scan_cnt[SCAN_DIV_BITS+1 -: 2];
  assign slot_end  = &scan_cnt[SCAN_DIV_BITS-1:0];
  assign scan_done = slot_end && (row_idx == 2'd3);

  // scan_en keeps all rows released while reset is asserted, since the
  // counter's reset value would otherwise select row 0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scan_cnt <= '0;
      scan_en  <= 1'b0;
    end else begin
      scan_cnt <= scan_cnt + 1'b1;
      scan_en  <= 1'b1;
    end
  end

  always_comb begin
    row_drv = '1;
    if (scan_en) row_drv[row_idx] = 1'b0;
  end

  // Two-flop synchronizer for the asynchronous column lines.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col_meta <= '1;
      col_sync <= '1;
    end else begin
      col_meta <= col_in;
      col_sync <= col_meta;
    end
  end

  // The current row's columns merged into the raw image; on the row-3
  // sample this is the completed scan handed to the debouncer.
  always_comb begin
    scan_image = raw_image;
    scan_image[row_idx*KBD_COLS +: KBD_COLS] = ~col_sync;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      raw_image <= '0;
    end else if (slot_end) begin
      raw_image <= scan_image;
    end
  end

  key_image_debounce #(
    .DEBOUNCE (DEBOUNCE)
  ) u_debounce (
    .clk       (clk),
    .rst       (rst),
    .scan_done (scan_done),
    .raw_image (scan_image),
    .key_down  (key_down),
    .new_press (new_press)
  );

  assign event_any  = |new_press;
  assign event_code = lowest_key(new_press);

  // Handshake: an ack coinciding with an event hands over the new code
  // directly; an event with no room sets the sticky overrun flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      key_valid <= 1'b0;
      key_code  <= '0;
      overrun   <= 1'b0;
    end else if (event_any) begin
      if (!key_valid || key_ack) begin
        key_valid <= 1'b1;
        key_code  <= event_code;
      end else begin
        overrun <= 1'b1;
      end
    end else if (key_ack) begin
      key_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_key_matrix_scanner.sv
// tb_key_matrix_scanner: directed and randomized bench for key_matrix_scanner
// with a keypad model driving col_in and a scan-level reference model.
module tb_key_matrix_scanner;

  localparam int SDB = 2;
  localparam int DEB = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  col_in;
  logic        key_ack = 1'b0;
  logic [3:0]  row_drv;
  logic        key_valid;
  logic [3:0]  key_code;
  logic [15:0] key_down;
  logic        overrun;

  logic [15:0] keys = '0;

  int passCount  = 0;
  int checkCount = 0;

  logic [15:0] mPrev;
  logic [15:0] mDown;
  int          mStable;
  logic        mValid;
  logic        mOverrun;
  logic [3:0]  mCode;

  always #5 clk = ~clk;

  // Physical keypad: a held key pulls its column low while its row is driven.
  always_comb begin
    col_in = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (!row_drv[r] && keys[r*4+c]) col_in[c] = 1'b0;
      end
    end
  end

  key_matrix_scanner #(
    .SCAN_DIV_BITS (SDB),
    .DEBOUNCE      (DEB)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .col_in    (col_in),
    .key_ack   (key_ack),
    .row_drv   (row_drv),
    .key_valid (key_valid),
    .key_code  (key_code),
    .key_down  (key_down),
    .overrun   (overrun)
  );

  task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checkCount++;
    assert (obs === exp) passCount++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic modelReset();
    mPrev    = '0;
    mDown    = '0;
    mStable  = 0;
    mValid   = 1'b0;
    mOverrun = 1'b0;
    mCode    = '0;
  endtask

  // One full scan at the level of the keypad behaviour: ackMode 1 acks early
  // in the scan, ackMode 2 acks on the clock the scan result lands.
  task automatic modelScan(input logic [15:0] img, input int ackMode);
    logic [15:0] newp;
    if (ackMode == 1) mValid = 1'b0;
    if (img == mPrev) mStable = (mStable >= DEB) ? DEB : mStable + 1;
    else              mStable = 1;
    mPrev = img;
    newp  = '0;
    if (mStable == DEB && img != mDown) begin
      newp  = img & ~mDown;
      mDown = img;
    end
    if (newp != 0) begin
      if (!mValid || ackMode == 2) begin
        mValid = 1'b1;
        mCode  = 4'($clog2(newp & (~newp + 16'd1)));
      end else begin
        mOverrun = 1'b1;
      end
    end else if (ackMode == 2) begin
      mValid = 1'b0;
    end
  endtask

  task automatic checkModel(input string tag);
    checkOutput({tag, "_valid"},   16'(key_valid), 16'(mValid));
    checkOutput({tag, "_code"},    16'(key_code),  16'(mCode));
    checkOutput({tag, "_down"},    key_down,       mDown);
    checkOutput({tag, "_overrun"}, 16'(overrun),   16'(mOverrun));
  endtask

  // Holds one key image for exactly one scan, starting on the negedge
  // just after a scan boundary, and checks outputs after the scan lands.
  task automatic applyStimulus(input logic [15:0] k, input int ackMode, input bit checkRows);
    logic [3:0] er;
    keys    = k;
    key_ack = (ackMode == 1);
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      key_ack = (ackMode == 2 && i == 15);
      if (checkRows && (i % 4) == 2) begin
        er = 4'hF;
        er[(i % 16) / 4] = 1'b0;
        checkOutput("row_drv", 16'(row_drv), 16'(er));
      end
    end
    modelScan(k, ackMode);
    checkModel("scan");
  endtask

  task automatic doReset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    modelReset();
  endtask

  initial begin
    logic [15:0] cur;
    int          mode;
    modelReset();
    $display("[TB] reset state");
    #2;
    checkOutput("rst_row_drv",  16'(row_drv),   16'hF);
    checkOutput("rst_valid",    16'(key_valid), 16'h0);
    checkOutput("rst_code",     16'(key_code),  16'h0);
    checkOutput("rst_down",     key_down,       16'h0);
    checkOutput("rst_overrun",  16'(overrun),   16'h0);
    @(negedge clk);
    rst = 1'b1;

    $display("[TB] idle scans");
    for (int s = 0; s < 10; s++) applyStimulus(16'h0000, 0, s < 3);

    $display("[TB] key 6");
    applyStimulus(16'h0040, 0, 0);
    checkOutput("k6_wait_valid", 16'(key_valid), 16'h0);
    applyStimulus(16'h0040, 0, 0);
    checkOutput("k6_valid", 16'(key_valid), 16'h1);
    checkOutput("k6_code",  16'(key_code),  16'h6);
    checkOutput("k6_down",  key_down,       16'h0040);
    applyStimulus(16'h0040, 1, 0);
    checkOutput("k6_ack_valid", 16'(key_valid), 16'h0);
    applyStimulus(16'h0000, 0, 0);
    applyStimulus(16'h0000, 0, 0);
    checkOutput("k6_rel_down",  key_down,       16'h0);
    checkOutput("k6_rel_valid", 16'(key_valid), 16'h0);

    $display("[TB] bounce key 9");
    for (int s = 0; s < 6; s++) begin
      applyStimulus((s % 2 == 0) ? 16'h0200 : 16'h0000, 0, 0);
      checkOutput("k9_bounce_valid", 16'(key_valid), 16'h0);
    end
    applyStimulus(16'h0200, 0, 0);
    checkOutput("k9_hold1_valid", 16'(key_valid), 16'h0);
    applyStimulus(16'h0200, 0, 0);
    checkOutput("k9_valid", 16'(key_valid), 16'h1);
    checkOutput("k9_code",  16'(key_code),  16'h9);
    applyStimulus(16'h0200, 1, 0);
    applyStimulus(16'h0000, 0, 0);
    applyStimulus(16'h0000, 0, 0);

    $display("[TB] keys 3 and 12 together");
    applyStimulus(16'h1008, 0, 0);
    applyStimulus(16'h1008, 0, 0);
    checkOutput("k3_12_code", 16'(key_code), 16'h3);
    checkOutput("k3_12_down", key_down,      16'h1008);
    applyStimulus(16'h1008, 0, 0);
    applyStimulus(16'h1008, 0, 0);
    checkOutput("k3_12_overrun", 16'(overrun),  16'h0);
    checkOutput("k3_12_code2",   16'(key_code), 16'h3);
    applyStimulus(16'h1008, 1, 0);
    applyStimulus(16'h0000, 0, 0);
    applyStimulus(16'h0000, 0, 0);

    $display("[TB] overrun");
    applyStimulus(16'h0002, 0, 0);
    applyStimulus(16'h0002, 0, 0);
    applyStimulus(16'h0000, 0, 0);
    applyStimulus(16'h0000, 0, 0);
    applyStimulus(16'h0020, 0, 0);
    applyStimulus(16'h0020, 0, 0);
    checkOutput("ovr_valid",   16'(key_valid), 16'h1);
    checkOutput("ovr_code",    16'(key_code),  16'h1);
    checkOutput("ovr_overrun", 16'(overrun),   16'h1);

    $display("[TB] reset mid-scan with key 15 held");
    keys = 16'h8000;
    repeat (7) @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("mid_rst_row_drv", 16'(row_drv),   16'hF);
    checkOutput("mid_rst_valid",   16'(key_valid), 16'h0);
    checkOutput("mid_rst_code",    16'(key_code),  16'h0);
    checkOutput("mid_rst_down",    key_down,       16'h0);
    checkOutput("mid_rst_overrun", 16'(overrun),   16'h0);
    @(negedge clk);
    rst = 1'b1;
    modelReset();
    applyStimulus(16'h8000, 0, 0);
    checkOutput("k15_wait_valid", 16'(key_valid), 16'h0);
    applyStimulus(16'h8000, 0, 0);
    checkOutput("k15_valid", 16'(key_valid), 16'h1);
    checkOutput("k15_code",  16'(key_code),  16'hF);

    $display("[TB] ack coinciding with event");
    applyStimulus(16'h8000, 1, 0);
    applyStimulus(16'h0000, 0, 0);
    applyStimulus(16'h0000, 0, 0);
    applyStimulus(16'h0002, 0, 0);
    applyStimulus(16'h0002, 0, 0);
    applyStimulus(16'h0000, 0, 0);
    applyStimulus(16'h0000, 0, 0);
    applyStimulus(16'h0020, 0, 0);
    applyStimulus(16'h0020, 2, 0);
    checkOutput("ackevt_valid",   16'(key_valid), 16'h1);
    checkOutput("ackevt_code",    16'(key_code),  16'h5);
    checkOutput("ackevt_overrun", 16'(overrun),   16'h0);

    $display("[TB] randomized scans");
    cur = '0;
    for (int s = 0; s < 80; s++) begin
      if ($urandom_range(0, 2) == 0) cur = 16'($urandom & $urandom & $urandom);
      mode = $urandom_range(0, 3);
      if (mode == 3) mode = 0;
      applyStimulus(cur, mode, 0);
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
